// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide sequencer that owns the HI/LO registers.
// MULT/MULTU use a WIDTH-step shift-add loop and DIV/DIVU use a WIDTH-step restoring divide.
// Signed operations run on operand magnitudes, and the signs are applied in the FIX state.
// Optional feature macro: MULDIV_MTHILO_EN adds write_hi/write_lo (MTHI/MTLO) ports.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       operation,
    input  logic [WIDTH-1:0] operando_1,
    input  logic [WIDTH-1:0] operando_2,
`ifdef MULDIV_MTHILO_EN
    input  logic             write_hi,
    input  logic             write_lo,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;        // product, or {remainder, quotient}
    logic [WIDTH-1:0]   opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;        // operand signs differ (signed ops only)
    logic               neg_rem_q, neg_rem_d; // dividend negative (signed divide only)
    logic               div_zero_q, div_zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               op_valid;
    logic               op_signed;
    logic               sgn1, sgn2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum;
    logic [ACC_W-1:0]   mul_step;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_rem;
    logic               div_bit;
    logic [ACC_W-1:0]   div_step;
    logic [ACC_W-1:0]   prod_fix;
    logic [WIDTH-1:0]   quo_raw, rem_raw;

    // State and result registers; reset clears everything immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // Next-state logic: operand capture, one loop iteration per cycle, and sign fix-up
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        op_valid  = (operation[5:2] == 4'b0110);
        op_signed = ~operation[0];
        sgn1      = op_signed & operando_1[WIDTH-1];
        sgn2      = op_signed & operando_2[WIDTH-1];
        mag1      = sgn1 ? WIDTH'(-operando_1) : operando_1;
        mag2      = sgn2 ? WIDTH'(-operando_2) : operando_2;

        // Shift-add: add the multiplicand into the upper half when the LSB is set, then shift right
        mul_sum   = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
        mul_step  = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: bring in the next dividend bit and subtract the divisor if it fits
        div_shift = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
        div_bit   = (div_shift >= {1'b0, opnd_q});
        div_rem   = div_bit ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
        div_step  = {div_rem, acc_q[WIDTH-2:0], div_bit};

        prod_fix  = neg_q ? ACC_W'(-acc_q) : acc_q;
        quo_raw   = acc_q[WIDTH-1:0];
        rem_raw   = acc_q[ACC_W-1:WIDTH];

        case (state_q)
            IDLE: begin
`ifdef MULDIV_MTHILO_EN
                if (write_hi || write_lo) begin
                    if (write_hi) hi_d = operando_1;
                    if (write_lo) lo_d = operando_1;
                end else
`endif
                if (start && op_valid) begin
                    state_d    = CALC;
                    cnt_d      = '0;
                    is_div_d   = operation[1];
                    neg_d      = sgn1 ^ sgn2;
                    neg_rem_d  = sgn1;
                    div_zero_d = (operando_2 == '0);
                    acc_d      = {WIDTH'(0), operation[1] ? mag1 : mag2};
                    opnd_d     = operation[1] ? mag2 : mag1;
                end
            end
            CALC: begin
                acc_d = is_div_q ? div_step : mul_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end
            end
            FIX: begin
                // A zero divisor leaves the raw dividend as remainder, so only the quotient needs forcing
                if (is_div_q) begin
                    lo_d = div_zero_q ? '1 : (neg_q ? WIDTH'(-quo_raw) : quo_raw);
                    hi_d = neg_rem_q ? WIDTH'(-rem_raw) : rem_raw;
                end else begin
                    hi_d = prod_fix[ACC_W-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit with an arithmetic reference model compared every cycle.
// Define MULDIV_MTHILO_EN to also exercise the MTHI/MTLO write ports.
module tb_muldiv_unit;

    localparam int unsigned WIDTH = 32;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [5:0]        operation;
    logic [WIDTH-1:0]  operando_1, operando_2;
    logic              write_hi, write_lo;
    logic              busy, done;
    logic [WIDTH-1:0]  hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .operation  (operation),
        .operando_1 (operando_1),
        .operando_2 (operando_2),
`ifdef MULDIV_MTHILO_EN
        .write_hi   (write_hi),
        .write_lo   (write_lo),
`endif
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    // Reference result as {hi, lo}, computed with plain 64-bit arithmetic
    function automatic logic [63:0] ref_result(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (op)
            F_MULT:  r = 64'(sa * sb);
            F_MULTU: r = {32'h0, a} * {32'h0, b};
            F_DIV:   r = (b == 32'h0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
            F_DIVU:  r = (b == 32'h0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Behavioural model: a request is accepted when nothing is pending, and its result lands WIDTH+1 edges later
    int          m_left = 0;
    logic [63:0] m_pend = '0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_busy;
    assign m_busy = (m_left > 0);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                end
`ifdef MULDIV_MTHILO_EN
            end else if (write_hi || write_lo) begin
                if (write_hi) m_hi <= operando_1;
                if (write_lo) m_lo <= operando_1;
`endif
            end else if (start && (operation[5:2] == 4'b0110)) begin
                m_pend <= ref_result(operation, operando_1, operando_2);
                m_left <= WIDTH + 1;
            end
        end
    end

    // Per-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        checks++;
        if (busy !== m_busy || done !== m_done || hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t got busy=%b done=%b hi=%h lo=%h want busy=%b done=%b hi=%h lo=%h",
                     $time, busy, done, hi, lo, m_busy, m_done, m_hi, m_lo);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Issue one request (called just after a rising edge) and wait for done; operands are scrambled while busy
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cycles);
        start = 1'b1; operation = op; operando_1 = a; operando_2 = b;
        lat = 0; busy_cycles = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                operando_1 = $urandom;
                operando_2 = $urandom;
            end
            if (busy) busy_cycles++;
        end while (!done && lat < 200);
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout op=%b got no done want done within 200 cycles", op);
        end
    endtask

    int lat, bc, n_done;
    logic seen_busy;
    logic [63:0] pin;

    initial begin
        reset = 1'b1; start = 1'b0; operation = '0;
        operando_1 = '0; operando_2 = '0; write_hi = 1'b0; write_lo = 1'b0;

        // Model pinned against hand-computed values
        pin = ref_result(F_DIV, 32'hFFFFFFF9, 32'd2);
        chk("model_div_neg7_lo", pin[31:0], 32'hFFFFFFFD);
        chk("model_div_neg7_hi", pin[63:32], 32'hFFFFFFFF);
        pin = ref_result(F_DIV, 32'h80000000, 32'hFFFFFFFF);
        chk("model_div_ovf_lo", pin[31:0], 32'h80000000);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: signed multiply with latency and busy-length checks
        run_op(F_MULT, 32'hFFFFFFFE, 32'd3, lat, bc);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);
        chk("mult_latency", 32'(lat), 32'd34);
        chk("mult_busy_cycles", 32'(bc), 32'd33);
        @(posedge clk); #1;

        // 2: unsigned multiply
        run_op(F_MULTU, 32'hFFFFFFFE, 32'd3, lat, bc);
        chk("multu_hi", hi, 32'h00000002);
        chk("multu_lo", lo, 32'hFFFFFFFA);
        @(posedge clk); #1;

        // 3: signed divide, then an unsigned divide started in the done cycle
        run_op(F_DIV, 32'hFFFFFFF9, 32'd2, lat, bc);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        run_op(F_DIVU, 32'd7, 32'd2, lat, bc);
        chk("divu_lo", lo, 32'h00000003);
        chk("divu_hi", hi, 32'h00000001);
        chk("divu_b2b_latency", 32'(lat), 32'd34);
        @(posedge clk); #1;

        // 4: divide-by-zero and signed overflow
        run_op(F_DIVU, 32'd7, 32'd0, lat, bc);
        chk("divu0_lo", lo, 32'hFFFFFFFF);
        chk("divu0_hi", hi, 32'h00000007);
        @(posedge clk); #1;
        run_op(F_DIV, 32'hFFFFFFF9, 32'd0, lat, bc);
        chk("div0_neg_lo", lo, 32'hFFFFFFFF);
        chk("div0_neg_hi", hi, 32'hFFFFFFF9);
        @(posedge clk); #1;
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc);
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_hi", hi, 32'h00000000);
        @(posedge clk); #1;

        // 5: invalid funct is ignored
        start = 1'b1; operation = 6'b100000; operando_1 = 32'd11; operando_2 = 32'd13;
        @(posedge clk); #1;
        start = 1'b0;
        seen_busy = 1'b0; n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) seen_busy = 1'b1;
            if (done) n_done++;
            @(posedge clk); #1;
        end
        chk("bad_funct_busy", 32'(seen_busy), 32'h0);
        chk("bad_funct_done", 32'(n_done), 32'h0);
        chk("bad_funct_hi", hi, 32'h0);
        chk("bad_funct_lo", lo, 32'h80000000);

        // 5: second start while busy is ignored
        start = 1'b1; operation = F_MULT; operando_1 = 32'd5; operando_2 = 32'd5;
        lat = 0; n_done = 0;
        while (lat < 80) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1)  start = 1'b0;
            if (lat == 10) begin start = 1'b1; operando_1 = 32'd9; operando_2 = 32'd9; end
            if (lat == 11) start = 1'b0;
            if (done) n_done++;
        end
        chk("busy_start_lo", lo, 32'd25);
        chk("busy_start_hi", hi, 32'd0);
        chk("busy_start_done_pulses", 32'(n_done), 32'd1);

        // 6: reset mid-operation, then a clean rerun
        start = 1'b1; operation = F_DIVU; operando_1 = 32'd100; operando_2 = 32'd7;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(F_DIVU, 32'd100, 32'd7, lat, bc);
        chk("rerun_lo", lo, 32'd14);
        chk("rerun_hi", hi, 32'd2);
        @(posedge clk); #1;

`ifdef MULDIV_MTHILO_EN
        // MTHI in idle, then MTLO winning over a simultaneous start
        write_hi = 1'b1; operando_1 = 32'h1234;
        @(posedge clk); #1;
        write_hi = 1'b0;
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_done", 32'(done), 32'h0);
        write_lo = 1'b1; start = 1'b1; operation = F_MULTU; operando_1 = 32'h5678; operando_2 = 32'd3;
        @(posedge clk); #1;
        write_lo = 1'b0; start = 1'b0;
        chk("mtlo_lo", lo, 32'h5678);
        chk("mtlo_busy", 32'(busy), 32'h0);
        repeat (3) @(posedge clk);
        #1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
